subservient_sram_arb: RTL and testbench

SUBSERVIENT_SRAM_ARB -- requirements
Module: subservient_sram_arb

---
 rtl/subservient_pkg.sv | 31 +++
 rtl/subservient_rr_arb.sv | 38 +++
 rtl/subservient_sram_arb.sv | 120 ++++++++++++
 tb/tb_subservient_sram_arb.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/subservient_pkg.sv
// Shared types for the SRAM arbiter: FSM state and the round-robin pick.
package subservient_pkg;

  localparam int unsigned MAX_CH = 8;
  localparam int unsigned PTR_W  = 3;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // One-hot grant of the first requester at or after ptr, wrapping at nch.
  function automatic logic [MAX_CH-1:0] rr_pick(input logic [MAX_CH-1:0] req,
                                                input logic [PTR_W-1:0]  ptr,
                                                input int unsigned       nch);
    logic [MAX_CH-1:0] gnt;
    logic              found;
    int unsigned       idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      idx = (32'(ptr) + i) % nch;
      if (i < nch && !found && req[PTR_W'(idx)]) begin
        gnt[PTR_W'(idx)] = 1'b1;
        found            = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/subservient_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant, priority pointer moves
// to the channel after the granted one whenever advance_i is set.
module subservient_rr_arb
  import subservient_pkg::*;
#(
  parameter int unsigned NCH = 2
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic [NCH-1:0] req_i,
  input  logic           advance_i,
  output logic [NCH-1:0] grant_o
);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  assign grant_o = NCH'(rr_pick(MAX_CH'(req_i), ptr_q, NCH));

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        if (grant_o[k]) begin
          ptr_d = (k == NCH - 1) ? '0 : PTR_W'(k + 1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/subservient_sram_arb.sv
// Multi-channel SRAM arbiter with optional zero-fill after reset and a
// one-cycle registered read-response strobe.
module subservient_sram_arb
  import subservient_pkg::*;
#(
  parameter int unsigned NCH            = 2,
  parameter int unsigned MEMSIZE        = 512,
  parameter int unsigned AW             = $clog2(MEMSIZE),
  parameter int unsigned DW             = 8,
  parameter bit          CLEAR_ON_RESET = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NCH-1:0]    i_req_valid,
  input  logic [NCH-1:0]    i_req_we,
  input  logic [NCH*AW-1:0] i_req_addr,
  input  logic [NCH*DW-1:0] i_req_wdata,
  output logic [NCH-1:0]    o_req_ready,
  output logic [NCH-1:0]    o_rsp_valid,
  output logic [DW-1:0]     o_rsp_rdata,
  output logic [AW-1:0]     o_sram_waddr,
  output logic [DW-1:0]     o_sram_wdata,
  output logic              o_sram_wen,
  output logic [AW-1:0]     o_sram_raddr,
  input  logic [DW-1:0]     i_sram_rdata
);

  state_e         state_q, state_d;
  logic [AW-1:0]  clr_cnt_q, clr_cnt_d;
  logic [AW-1:0]  waddr_q, waddr_d;
  logic [AW-1:0]  raddr_q, raddr_d;
  logic [NCH-1:0] rsp_valid_q, rsp_valid_d;
  logic [NCH-1:0] grant_c;
  logic           run_c;
  logic           clear_c;
  logic           sel_we_c;
  logic [AW-1:0]  sel_addr_c;
  logic [DW-1:0]  sel_wdata_c;

  // Qualify with reset so nothing is granted or written while held in reset.
  assign run_c   = i_rst_n && (state_q == ST_RUN);
  assign clear_c = i_rst_n && (state_q == ST_CLEAR);

  subservient_rr_arb #(
    .NCH(NCH)
  ) u_arb (
    .clk_i    (i_clk),
    .rst_n_i  (i_rst_n),
    .req_i    (i_req_valid & {NCH{run_c}}),
    .advance_i(run_c),
    .grant_o  (grant_c)
  );

  assign o_req_ready = grant_c;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = i_sram_rdata;

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    waddr_d      = waddr_q;
    raddr_d      = raddr_q;
    rsp_valid_d  = '0;
    sel_we_c     = 1'b0;
    sel_addr_c   = '0;
    sel_wdata_c  = '0;
    o_sram_wen   = 1'b0;
    o_sram_wdata = '0;
    o_sram_waddr = waddr_q;
    o_sram_raddr = raddr_q;

    for (int unsigned k = 0; k < NCH; k++) begin
      if (grant_c[k]) begin
        sel_we_c    = i_req_we[k];
        sel_addr_c  = i_req_addr[k*AW +: AW];
        sel_wdata_c = i_req_wdata[k*DW +: DW];
      end
    end

    if (clear_c) begin
      o_sram_wen   = 1'b1;
      o_sram_waddr = clr_cnt_q;
      o_sram_raddr = clr_cnt_q;
      waddr_d      = clr_cnt_q;
      raddr_d      = clr_cnt_q;
      clr_cnt_d    = clr_cnt_q + AW'(1);
      if (clr_cnt_q == AW'(MEMSIZE - 1)) begin
        state_d = ST_RUN;
      end
    end else if (|grant_c) begin
      if (sel_we_c) begin
        o_sram_wen   = 1'b1;
        o_sram_waddr = sel_addr_c;
        o_sram_wdata = sel_wdata_c;
        waddr_d      = sel_addr_c;
      end else begin
        o_sram_raddr = sel_addr_c;
        raddr_d      = sel_addr_c;
        rsp_valid_d  = grant_c;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clr_cnt_q   <= '0;
      waddr_q     <= '0;
      raddr_q     <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      waddr_q     <= waddr_d;
      raddr_q     <= raddr_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

endmodule

// File: tb/tb_subservient_sram_arb.sv
// Directed bench: a 2-channel arbiter with zero-fill and a 4-channel one
// without, each driving a simple 1-cycle-latency SRAM model.
module tb_subservient_sram_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // 2-channel instance, 512 x 8
  logic [1:0]  v2, we2, rdy2, rsp2;
  logic [17:0] addr2;
  logic [15:0] wd2;
  logic [7:0]  rdata2, srd2, swd2;
  logic [8:0]  swa2, sra2;
  logic        swen2;
  logic [7:0]  mem2 [512];

  subservient_sram_arb #(
    .NCH(2), .MEMSIZE(512), .DW(8), .CLEAR_ON_RESET(1'b1)
  ) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(v2), .i_req_we(we2), .i_req_addr(addr2), .i_req_wdata(wd2),
    .o_req_ready(rdy2), .o_rsp_valid(rsp2), .o_rsp_rdata(rdata2),
    .o_sram_waddr(swa2), .o_sram_wdata(swd2), .o_sram_wen(swen2),
    .o_sram_raddr(sra2), .i_sram_rdata(srd2)
  );

  always @(posedge clk) begin
    if (swen2) mem2[swa2] <= swd2;
    srd2 <= mem2[sra2];
  end

  // 4-channel instance, 16 x 8, no clear
  logic [3:0]  v4, we4, rdy4, rsp4;
  logic [15:0] addr4;
  logic [31:0] wd4;
  logic [7:0]  rdata4, srd4, swd4;
  logic [3:0]  swa4, sra4;
  logic        swen4;
  logic [7:0]  mem4 [16];

  subservient_sram_arb #(
    .NCH(4), .MEMSIZE(16), .DW(8), .CLEAR_ON_RESET(1'b0)
  ) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(v4), .i_req_we(we4), .i_req_addr(addr4), .i_req_wdata(wd4),
    .o_req_ready(rdy4), .o_rsp_valid(rsp4), .o_rsp_rdata(rdata4),
    .o_sram_waddr(swa4), .o_sram_wdata(swd4), .o_sram_wen(swen4),
    .o_sram_raddr(sra4), .i_sram_rdata(srd4)
  );

  always @(posedge clk) begin
    if (swen4) mem4[swa4] <= swd4;
    srd4 <= mem4[sra4];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [1:0] exp_g [4];
  logic [1:0] prev_g;

  initial begin
    v2 = '0; we2 = '0; addr2 = '0; wd2 = '0;
    v4 = '0; we4 = '0; addr4 = '0; wd4 = '0;

    // Held in reset with requests pending: nothing granted or written.
    @(negedge clk);
    v2 = 2'b11; v4 = 4'b1111;
    #1;
    check_eq("rst_ready2", 32'(rdy2), 32'h0);
    check_eq("rst_rsp2",   32'(rsp2), 32'h0);
    check_eq("rst_wen2",   32'(swen2), 32'h0);
    check_eq("rst_ready4", 32'(rdy4), 32'h0);
    check_eq("rst_wen4",   32'(swen4), 32'h0);
    v4 = '0;
    tick();

    // Zero-fill: 512 writes, ascending address, requests blocked.
    rst_n = 1'b1;
    for (int i = 0; i < 512; i++) begin
      #1;
      check_eq("clr_wen",   32'(swen2), 32'h1);
      check_eq("clr_waddr", 32'(swa2), 32'(i));
      check_eq("clr_wdata", 32'(swd2), 32'h0);
      check_eq("clr_ready", 32'(rdy2), 32'h0);
      tick();
    end
    #1;
    check_eq("run_ready", 32'(rdy2), 32'h1);
    v2 = 2'b00;
    tick();

    // ch0 write 0x5A @0x010 then read it back.
    v2 = 2'b01; we2 = 2'b01; addr2 = {9'h000, 9'h010}; wd2 = {8'h00, 8'h5A};
    #1;
    check_eq("wr_ready", 32'(rdy2), 32'h1);
    check_eq("wr_wen",   32'(swen2), 32'h1);
    check_eq("wr_waddr", 32'(swa2), 32'h010);
    check_eq("wr_wdata", 32'(swd2), 32'h5A);
    tick();
    we2 = 2'b00;
    #1;
    check_eq("rd_ready", 32'(rdy2), 32'h1);
    check_eq("rd_wen",   32'(swen2), 32'h0);
    check_eq("rd_raddr", 32'(sra2), 32'h010);
    tick();
    v2 = 2'b00;
    #1;
    check_eq("rd_rsp",   32'(rsp2), 32'h1);
    check_eq("rd_rdata", 32'(rdata2), 32'h5A);
    check_eq("idle_wen", 32'(swen2), 32'h0);
    check_eq("idle_raddr_hold", 32'(sra2), 32'h010);
    tick();
    #1;
    check_eq("rd_rsp_once", 32'(rsp2), 32'h0);

    // ch1 writes 0x33 @0x020, then both channels read continuously.
    v2 = 2'b10; we2 = 2'b10; addr2 = {9'h020, 9'h010}; wd2 = {8'h33, 8'h00};
    #1;
    check_eq("wr1_ready", 32'(rdy2), 32'h2);
    tick();
    v2 = 2'b11; we2 = 2'b00;
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    prev_g = 2'b00;
    for (int c = 0; c < 4; c++) begin
      #1;
      check_eq("rr_grant", 32'(rdy2), 32'(exp_g[c]));
      check_eq("rr_raddr", 32'(sra2), (exp_g[c] == 2'b01) ? 32'h010 : 32'h020);
      if (c > 0) begin
        check_eq("rr_rsp",   32'(rsp2), 32'(prev_g));
        check_eq("rr_rdata", 32'(rdata2), (prev_g == 2'b01) ? 32'h5A : 32'h33);
      end
      prev_g = exp_g[c];
      tick();
    end
    v2 = 2'b00;
    #1;
    check_eq("rr_rsp_last",   32'(rsp2), 32'h2);
    check_eq("rr_rdata_last", 32'(rdata2), 32'h33);
    tick();

    // ch1 writes 0xFF @0x1FF; ch0 reads 0x1FF then 0x000.
    v2 = 2'b10; we2 = 2'b10; addr2 = {9'h1FF, 9'h000}; wd2 = {8'hFF, 8'h00};
    #1;
    check_eq("top_wr_ready", 32'(rdy2), 32'h2);
    check_eq("top_wr_waddr", 32'(swa2), 32'h1FF);
    tick();
    v2 = 2'b01; we2 = 2'b00; addr2 = {9'h000, 9'h1FF};
    #1;
    check_eq("top_rd_ready", 32'(rdy2), 32'h1);
    tick();
    addr2 = {9'h000, 9'h000};
    #1;
    check_eq("top_rd_rsp",   32'(rsp2), 32'h1);
    check_eq("top_rd_rdata", 32'(rdata2), 32'hFF);
    check_eq("zero_rd_ready", 32'(rdy2), 32'h1);
    tick();
    v2 = 2'b00;
    #1;
    check_eq("zero_rd_rsp",   32'(rsp2), 32'h1);
    check_eq("zero_rd_rdata", 32'(rdata2), 32'h00);
    check_eq("waddr_hold",    32'(swa2), 32'h1FF);
    tick();

    // 4-channel round-robin: ch1 granted, then lone ch3, then ch0 vs ch3.
    v4 = 4'b0010;
    #1;
    check_eq("n4_ch1", 32'(rdy4), 32'h2);
    tick();
    v4 = 4'b1000;
    #1;
    check_eq("n4_rsp_ch1", 32'(rsp4), 32'h2);
    check_eq("n4_ch3_alone", 32'(rdy4), 32'h8);
    tick();
    v4 = 4'b1001;
    #1;
    check_eq("n4_rsp_ch3", 32'(rsp4), 32'h8);
    check_eq("n4_ch0_wins", 32'(rdy4), 32'h1);
    tick();
    #1;
    check_eq("n4_ch3_next", 32'(rdy4), 32'h8);
    tick();
    v4 = 4'b0000;
    #1;
    check_eq("n4_idle", 32'(rdy4), 32'h0);

    // Reset right after a read grant: response dropped, clear restarts at 0.
    v2 = 2'b01; we2 = 2'b00; addr2 = {9'h000, 9'h010};
    #1;
    check_eq("pre_rst_ready", 32'(rdy2), 32'h1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_eq("abort_rsp",   32'(rsp2), 32'h0);
    check_eq("abort_ready", 32'(rdy2), 32'h0);
    check_eq("abort_wen",   32'(swen2), 32'h0);
    tick();
    v2 = 2'b00;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("reclr_wen",   32'(swen2), 32'h1);
      check_eq("reclr_waddr", 32'(swa2), 32'(i));
      check_eq("reclr_rsp",   32'(rsp2), 32'h0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
